// File: rtl/priority_encoder_stream_if.sv
// Stream bundle for the priority encoder: vector in, index beats out.
// The slave modport is the encoder's view; master is the producer/consumer side.
interface priority_encoder_stream_if #(
  parameter int N = 4
);
  localparam int W = $clog2(N);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_vec;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_last;
  logic [W:0]   out_cnt;
  logic         zero_drop;

  modport slave (
    input  in_valid,
    input  in_vec,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_idx,
    output out_last,
    output out_cnt,
    output zero_drop
  );

  modport master (
    output in_valid,
    output in_vec,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_idx,
    input  out_last,
    input  out_cnt,
    input  zero_drop
  );
endinterface

// File: rtl/priority_encoder_stream.sv
// Sequential priority encoder: drains a multi-hot vector as a stream
// of binary indices, lowest set bit first.
module priority_encoder_stream #(
  parameter int N = 4
) (
  input logic clk,
  input logic rst,
  input logic en,
  priority_encoder_stream_if.slave s
);
  localparam int W = $clog2(N);
  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic [N-1:0] pend_q;
  logic [N-1:0] pend_d;
  logic [W:0]   cnt_q;
  logic [W:0]   cnt_d;
  logic         zdrop_q;
  logic         zdrop_d;

  logic [W-1:0] low;
  logic         single;
  logic         draining;
  logic         idle;

  function automatic logic [W:0] popcnt(
    input logic [N-1:0] v
  );
    logic [W:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + (W+1)'(v[i]);
    end
    return c;
  endfunction

  // Descending scan so the lowest set bit wins.
  always_comb begin
    low = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        low = W'(i);
      end
    end
  end

  assign single = (pend_q != '0) &&
                  ((pend_q & (pend_q - ONE)) == '0);

  assign draining = (state_q == DRAIN);
  assign idle     = (state_q == IDLE);

  assign s.in_ready  = ~rst & en & idle;
  assign s.out_valid = ~rst & en & draining;
  assign s.out_idx   = draining ? low : '0;
  assign s.out_last  = draining & single;
  assign s.out_cnt   = cnt_q;
  assign s.zero_drop = zdrop_q;

  // With en low every register holds, including a pending zero_drop.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    zdrop_d = zdrop_q;
    if (en) begin
      zdrop_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (s.in_valid) begin
            if (s.in_vec != '0) begin
              pend_d  = s.in_vec;
              cnt_d   = popcnt(s.in_vec);
              state_d = DRAIN;
            end else begin
              zdrop_d = 1'b1;
            end
          end
        end
        DRAIN: begin
          if (s.out_ready) begin
            pend_d = pend_q & (pend_q - ONE);
            if (single) begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      cnt_q   <= '0;
      zdrop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      zdrop_q <= zdrop_d;
    end
  end
endmodule

// File: doc/priority_encoder_stream.md
Name: priority_encoder_stream

Overview:
- Sequential N-to-log2(N) encoder, the inverse of the 2-to-4 enable decoder.
- Accepts a multi-hot request vector over a valid/ready handshake.
- Emits the binary index of every set bit, one index per accepted output beat, lowest index first.
- Sits between request-collecting logic and index-driven consumers (decoder selects, mux controls).

Parameters:
- N, 4, width of the request vector; legal values 2..32, power of two.
- W, $clog2(N) (=2), width of the encoded index; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- en  input  1  global enable; 0 stalls the block with all state held
- in_valid  input  1  in_vec is presented
- in_ready  output  1  block can accept a vector this cycle
- in_vec  input  N  multi-hot request vector; bit i requests index i
- out_valid  output  1  out_idx is valid
- out_ready  input  1  consumer takes out_idx this cycle
- out_idx  output  W  binary index of the lowest pending set bit
- out_last  output  1  current beat is the final index of this vector
- out_cnt  output  W+1  popcount of the vector being drained, held for the whole drain
- zero_drop  output  1  one-cycle pulse: an all-zero vector was accepted and discarded

Behaviour:
- Reset (rst=1 at a clk edge):
  - State returns to IDLE; pending register and out_cnt are cleared to 0; zero_drop=0.
  - in_ready and out_valid are forced to 0 while rst=1, regardless of state.
  - Reset mid-drain discards all remaining indices; nothing further is emitted.
- States: IDLE and DRAIN.
- IDLE:
  - in_ready = en. out_valid = 0. out_idx = 0. out_last = 0.
  - Accept when in_valid & in_ready.
  - Accept with in_vec != 0: pending <= in_vec; out_cnt <= popcount(in_vec); next state DRAIN.
  - Accept with in_vec == 0: zero_drop pulses 1 on the next cycle; state stays IDLE; out_cnt is unchanged.
- DRAIN:
  - in_ready = 0; there is no overlap between vectors.
  - out_valid = en.
  - out_idx = index of the lowest set bit of pending (combinational from the pending register).
  - out_last = 1 when pending has exactly one bit set.
  - A beat transfers when out_valid & out_ready. On transfer, the emitted bit is cleared from pending.
  - If that beat had out_last=1, next state is IDLE and pending becomes 0.
  - out_idx, out_last and out_valid must hold stable while out_valid=1 and out_ready=0.
- Latency:
  - The first out_valid asserts the cycle after the input is accepted.
  - Each further index follows one cycle after the previous transfer when out_ready is held high.
  - A vector with k set bits drains in exactly k cycles under continuous ready.
  - The next in_ready comes one cycle after the last transfer, giving k+1 cycles per vector (k≥1) at full throughput.
- en=0:
  - in_ready=0 and out_valid=0.
  - State, pending, out_cnt and zero_drop do not change; any zero_drop pulse is deferred.
  - Inputs are ignored.
- Simultaneous events:
  - in_valid asserted during DRAIN is ignored; the upstream holds its vector.
  - rst takes priority over en and over any handshake.
- Widths: popcount of an all-ones vector is N, so out_cnt is W+1 bits. out_idx never exceeds N-1.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then rst=0, en=1 -> in_ready=1, out_valid=0, out_cnt=0, zero_drop=0.
- Single bit, N=4: in_vec=4'b0100 accepted, out_ready=1 -> next cycle out_valid=1, out_idx=2, out_last=1, out_cnt=1; the following cycle in_ready=1.
- Multi-hot with backpressure: in_vec=4'b1011; out_ready low for 3 cycles, then high.
  - out_idx=0 is held stable while ready is low.
  - The sequence is then 0, 1, 3 with out_last only on 3, and out_cnt=3 throughout.
  - in_ready stays 0 until IDLE; a new in_valid during the drain is not accepted.
- All-ones then zero: in_vec=4'b1111 -> indices 0, 1, 2, 3 in 4 consecutive cycles with out_cnt=4. Next, in_vec=4'b0000 -> zero_drop=1 for one cycle, no out_valid.
- Stall: en=0 mid-drain of 4'b1010 after index 1 is emitted -> out_valid=0 and state is held. en=1 -> out_idx=3, out_last=1.
- Reset mid-drain: rst=1 while draining 4'b1110 after index 1 -> out_valid=0 the next cycle. After release, in_ready=1 and index 2 or 3 is never emitted.
